// File: rtl/elastic_pipe_regs.sv
// elastic_pipe_regs
// A chain of DEPTH payload registers with per-stage valid bits and a
// valid/ready handshake at both ends. Stage 0 is the youngest (input side),
// stage DEPTH-1 the oldest (output side). Entries either advance elastically
// (an entry moves whenever the stage ahead is free) or in lockstep (one
// global enable shifts the whole chain). A partial flush kills every entry
// younger than flush_idx, e.g. on a taken branch resolved further down.
module elastic_pipe_regs #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter bit BUBBLE_COLLAPSE = 1'b1,
    localparam int IDXW = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    input  logic                    flush,
    input  logic [IDXW-1:0]         flush_idx,
    output logic [DEPTH-1:0]        stage_valid,
    output logic [DEPTH*WIDTH-1:0]  stage_data,
    output logic [IDXW-1:0]         count
);

    // Number of set bits in a stage-valid vector.
    function automatic logic [IDXW-1:0] popcount(input logic [DEPTH-1:0] v);
        logic [IDXW-1:0] n;
        n = '0;
        for (int i = 0; i < DEPTH; i++) begin
            n = n + IDXW'(v[i]);
        end
        return n;
    endfunction

    logic [DEPTH-1:0] valid_r;
    logic [WIDTH-1:0] data_r [DEPTH];
    logic [IDXW-1:0]  count_r;

    logic [DEPTH-1:0] kill_s;
    logic [DEPTH-1:0] ev_s;
    logic [DEPTH-1:0] adv_s;
    logic             lock_en_s;
    logic             in_ready_s;
    logic [DEPTH-1:0] valid_nxt_s;
    logic [WIDTH-1:0] data_nxt_s [DEPTH];

    // Stages younger than flush_idx are killed; an index past DEPTH kills all.
    always_comb begin
        kill_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (flush && (int'(flush_idx) > i)) begin
                kill_s[i] = 1'b1;
            end else begin
                kill_s[i] = 1'b0;
            end
        end
    end

    assign ev_s = valid_r & ~kill_s;

    // Ready chain from output to input: a stage advances when the one ahead
    // is empty or itself advancing. Built with a running scalar so the chain
    // never reads back its own vector.
    always_comb begin
        logic a;
        adv_s          = '0;
        a              = out_ready | ~ev_s[DEPTH-1];
        adv_s[DEPTH-1] = a;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            a        = ~ev_s[i+1] | a;
            adv_s[i] = a;
        end
    end

    assign lock_en_s = out_ready | ~ev_s[DEPTH-1];

    // Next-state valid bits and payloads for either advance mode. Killed
    // entries never move and simply drop out at the edge.
    always_comb begin
        valid_nxt_s = '0;
        in_ready_s  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            data_nxt_s[i] = data_r[i];
        end
        if (BUBBLE_COLLAPSE) begin
            in_ready_s = (~ev_s[0] | adv_s[0]) & ~flush;
            if (in_valid && in_ready_s) begin
                valid_nxt_s[0] = 1'b1;
                data_nxt_s[0]  = in_data;
            end else if (adv_s[0]) begin
                valid_nxt_s[0] = 1'b0;
            end else begin
                valid_nxt_s[0] = ev_s[0];
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (adv_s[i-1] && ev_s[i-1]) begin
                    valid_nxt_s[i] = 1'b1;
                    data_nxt_s[i]  = data_r[i-1];
                end else if (adv_s[i]) begin
                    valid_nxt_s[i] = 1'b0;
                end else begin
                    valid_nxt_s[i] = ev_s[i];
                end
            end
        end else begin
            in_ready_s = lock_en_s & ~flush;
            if (lock_en_s) begin
                valid_nxt_s[0] = in_valid & ~flush;
                data_nxt_s[0]  = in_data;
                for (int i = 1; i < DEPTH; i++) begin
                    valid_nxt_s[i] = ev_s[i-1];
                    data_nxt_s[i]  = data_r[i-1];
                end
            end else begin
                valid_nxt_s = ev_s;
            end
        end
    end

    // Stage registers; count is kept registered alongside the valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= '0;
            count_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= '0;
            end
        end else begin
            valid_r <= valid_nxt_s;
            count_r <= popcount(valid_nxt_s);
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= data_nxt_s[i];
            end
        end
    end

    // Flatten the stage payloads onto the tap bus.
    always_comb begin
        stage_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            stage_data[i*WIDTH +: WIDTH] = data_r[i];
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = valid_r[DEPTH-1];
    assign out_data    = data_r[DEPTH-1];
    assign stage_valid = valid_r;
    assign count       = count_r;

endmodule

// File: tb/tb_elastic_pipe_regs.sv
// Bench for elastic_pipe_regs: one elastic and one lockstep instance share
// the same stimulus; a slot-level reference model predicts both.
module tb_elastic_pipe_regs;
    localparam int W  = 64;
    localparam int D  = 4;
    localparam int IW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          flush = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic [IW-1:0] flush_idx = '0;

    logic          e_in_ready, e_out_valid, l_in_ready, l_out_valid;
    logic [W-1:0]  e_out_data, l_out_data;
    logic [D-1:0]  e_sv, l_sv;
    logic [D*W-1:0] e_sd, l_sd;
    logic [IW-1:0] e_cnt, l_cnt;

    int checks = 0;
    int errors = 0;

    // reference model: index 0 elastic, 1 lockstep
    bit           mv [2][D];
    logic [W-1:0] md [2][D];
    bit           nv [2][D];
    logic [W-1:0] nd [2][D];
    bit           exp_rdy [2];
    bit           exp_xfer [2];
    int           mdl_xfer [2];
    int           dut_xfer [2];

    typedef struct {
        bit           iv;
        logic [W-1:0] id;
        bit           ordy;
        bit           e_rdy;
        bit           e_ov;
        logic [W-1:0] e_od;
        logic [IW-1:0] e_cnt;
    } vec_t;
    vec_t vt [20];

    elastic_pipe_regs #(.WIDTH(W), .DEPTH(D), .BUBBLE_COLLAPSE(1'b1)) u_ela (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(e_in_ready),
        .in_data(in_data), .out_valid(e_out_valid), .out_ready(out_ready),
        .out_data(e_out_data), .flush(flush), .flush_idx(flush_idx),
        .stage_valid(e_sv), .stage_data(e_sd), .count(e_cnt));

    elastic_pipe_regs #(.WIDTH(W), .DEPTH(D), .BUBBLE_COLLAPSE(1'b0)) u_lck (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(l_in_ready),
        .in_data(in_data), .out_valid(l_out_valid), .out_ready(out_ready),
        .out_data(l_out_data), .flush(flush), .flush_idx(flush_idx),
        .stage_valid(l_sv), .stage_data(l_sd), .count(l_cnt));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input bit iv, input logic [W-1:0] id, input bit ordy,
                                input bit rdy, input bit ov, input logic [W-1:0] od,
                                input logic [IW-1:0] cnt);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy;
        v.e_rdy = rdy; v.e_ov = ov; v.e_od = od; v.e_cnt = cnt;
        return v;
    endfunction

    task automatic model_clear();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < D; i++) begin
                mv[m][i] = 1'b0;
                md[m][i] = '0;
            end
        end
    endtask

    // One slot-level step: killed entries vanish, then entries move oldest
    // first into free slots (elastic) or all shift together (lockstep).
    task automatic model_eval(input int m);
        bit alive [D];
        bit en;
        for (int i = 0; i < D; i++) begin
            alive[i] = mv[m][i] && !(flush && (int'(flush_idx) > i));
            nv[m][i] = 1'b0;
            nd[m][i] = md[m][i];
        end
        exp_xfer[m] = mv[m][D-1] && out_ready;
        if (m == 0) begin
            for (int p = D - 1; p >= 0; p--) begin
                if (alive[p]) begin
                    if (p == D - 1) begin
                        if (!out_ready) nv[m][p] = 1'b1;
                    end else if (!nv[m][p+1]) begin
                        nv[m][p+1] = 1'b1;
                        nd[m][p+1] = md[m][p];
                    end else begin
                        nv[m][p] = 1'b1;
                    end
                end
            end
            exp_rdy[m] = !flush && !nv[m][0];
            if (in_valid && exp_rdy[m]) begin
                nv[m][0] = 1'b1;
                nd[m][0] = in_data;
            end
        end else begin
            en = !alive[D-1] || out_ready;
            exp_rdy[m] = en && !flush;
            if (en) begin
                for (int i = D - 1; i > 0; i--) begin
                    nv[m][i] = alive[i-1];
                    nd[m][i] = md[m][i-1];
                end
                nv[m][0] = in_valid && !flush;
                nd[m][0] = in_data;
            end else begin
                for (int i = 0; i < D; i++) nv[m][i] = alive[i];
            end
        end
    endtask

    task automatic cmp_mode(input int m, input string tag, input logic rdy, input logic ov,
                            input logic [W-1:0] od, input logic [D-1:0] sv,
                            input logic [D*W-1:0] sd, input logic [IW-1:0] cnt);
        logic [D-1:0]  esv;
        logic [IW-1:0] ecnt;
        esv = '0;
        ecnt = '0;
        for (int i = 0; i < D; i++) begin
            esv[i] = mv[m][i];
            ecnt = ecnt + IW'(mv[m][i]);
        end
        chk({tag, "_in_ready"}, W'(rdy), W'(exp_rdy[m]));
        chk({tag, "_out_valid"}, W'(ov), W'(mv[m][D-1]));
        chk({tag, "_stage_valid"}, W'(sv), W'(esv));
        chk({tag, "_count"}, W'(cnt), W'(ecnt));
        if (mv[m][D-1]) chk({tag, "_out_data"}, od, md[m][D-1]);
        for (int i = 0; i < D; i++) begin
            if (mv[m][i]) chk({tag, "_stage_data"}, sd[i*W +: W], md[m][i]);
        end
        if (ov && out_ready) dut_xfer[m]++;
        if (exp_xfer[m]) mdl_xfer[m]++;
    endtask

    task automatic drive(input bit iv, input logic [W-1:0] id, input bit ordy,
                         input bit fl, input logic [IW-1:0] fi);
        in_valid = iv; in_data = id; out_ready = ordy; flush = fl; flush_idx = fi;
    endtask

    task automatic mid_check();
        @(negedge clk);
        model_eval(0);
        model_eval(1);
        cmp_mode(0, "ela", e_in_ready, e_out_valid, e_out_data, e_sv, e_sd, e_cnt);
        cmp_mode(1, "lck", l_in_ready, l_out_valid, l_out_data, l_sv, l_sd, l_cnt);
    endtask

    task automatic end_cycle();
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < D; i++) begin
                mv[m][i] = nv[m][i];
                md[m][i] = nd[m][i];
            end
        end
        #1;
    endtask

    task automatic run_cycle(input bit iv, input logic [W-1:0] id, input bit ordy,
                             input bit fl, input logic [IW-1:0] fi);
        drive(iv, id, ordy, fl, fi);
        mid_check();
        end_cycle();
    endtask

    task automatic drain();
        for (int k = 0; k < 6; k++) run_cycle(1'b0, '0, 1'b1, 1'b0, '0);
    endtask

    initial begin
        int lat;
        bit found;
        model_clear();
        for (int m = 0; m < 2; m++) begin
            mdl_xfer[m] = 0;
            dut_xfer[m] = 0;
        end

        // streaming 1,2,3 then fill/stall/single-transfer with 0xA0..0xA4
        vt[0]  = mk(1'b1, 64'h1,  1'b1, 1'b1, 1'b0, 64'h0,  3'd0);
        vt[1]  = mk(1'b1, 64'h2,  1'b1, 1'b1, 1'b0, 64'h0,  3'd1);
        vt[2]  = mk(1'b1, 64'h3,  1'b1, 1'b1, 1'b0, 64'h0,  3'd2);
        vt[3]  = mk(1'b0, 64'h0,  1'b1, 1'b1, 1'b0, 64'h0,  3'd3);
        vt[4]  = mk(1'b0, 64'h0,  1'b1, 1'b1, 1'b1, 64'h1,  3'd3);
        vt[5]  = mk(1'b0, 64'h0,  1'b1, 1'b1, 1'b1, 64'h2,  3'd2);
        vt[6]  = mk(1'b0, 64'h0,  1'b1, 1'b1, 1'b1, 64'h3,  3'd1);
        vt[7]  = mk(1'b0, 64'h0,  1'b1, 1'b1, 1'b0, 64'h0,  3'd0);
        vt[8]  = mk(1'b1, 64'hA0, 1'b0, 1'b1, 1'b0, 64'h0,  3'd0);
        vt[9]  = mk(1'b1, 64'hA1, 1'b0, 1'b1, 1'b0, 64'h0,  3'd1);
        vt[10] = mk(1'b1, 64'hA2, 1'b0, 1'b1, 1'b0, 64'h0,  3'd2);
        vt[11] = mk(1'b1, 64'hA3, 1'b0, 1'b1, 1'b0, 64'h0,  3'd3);
        vt[12] = mk(1'b1, 64'hA4, 1'b0, 1'b0, 1'b1, 64'hA0, 3'd4);
        vt[13] = mk(1'b1, 64'hA4, 1'b1, 1'b1, 1'b1, 64'hA0, 3'd4);
        vt[14] = mk(1'b0, 64'h0,  1'b0, 1'b0, 1'b1, 64'hA1, 3'd4);
        vt[15] = mk(1'b0, 64'h0,  1'b1, 1'b1, 1'b1, 64'hA1, 3'd4);
        vt[16] = mk(1'b0, 64'h0,  1'b1, 1'b1, 1'b1, 64'hA2, 3'd3);
        vt[17] = mk(1'b0, 64'h0,  1'b1, 1'b1, 1'b1, 64'hA3, 3'd2);
        vt[18] = mk(1'b0, 64'h0,  1'b1, 1'b1, 1'b1, 64'hA4, 3'd1);
        vt[19] = mk(1'b0, 64'h0,  1'b1, 1'b1, 1'b0, 64'h0,  3'd0);

        // reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst_stage_valid", W'(e_sv), W'(4'b0000));
        chk("rst_out_valid", W'(e_out_valid), W'(1'b0));
        chk("rst_count", W'(e_cnt), W'(3'd0));
        chk("rst_in_ready", W'(e_in_ready), W'(1'b1));
        chk("rst_lck_stage_valid", W'(l_sv), W'(4'b0000));
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // directed table
        for (int r = 0; r < 20; r++) begin
            drive(vt[r].iv, vt[r].id, vt[r].ordy, 1'b0, '0);
            mid_check();
            chk("tbl_in_ready", W'(e_in_ready), W'(vt[r].e_rdy));
            chk("tbl_out_valid", W'(e_out_valid), W'(vt[r].e_ov));
            chk("tbl_count", W'(e_cnt), W'(vt[r].e_cnt));
            if (vt[r].e_ov) chk("tbl_out_data", e_out_data, vt[r].e_od);
            end_cycle();
        end

        // bubble squeeze vs lockstep hold with stage 0 and stage 3 occupied
        run_cycle(1'b1, 64'hC0, 1'b0, 1'b0, '0);
        run_cycle(1'b0, '0, 1'b0, 1'b0, '0);
        run_cycle(1'b0, '0, 1'b0, 1'b0, '0);
        run_cycle(1'b1, 64'hC1, 1'b0, 1'b0, '0);
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        mid_check();
        chk("bub_ela_sv0", W'(e_sv), W'(4'b1001));
        chk("bub_lck_sv0", W'(l_sv), W'(4'b1001));
        end_cycle();
        mid_check();
        chk("bub_ela_sv1", W'(e_sv), W'(4'b1010));
        chk("bub_lck_sv1", W'(l_sv), W'(4'b1001));
        end_cycle();
        drain();

        // partial flush on a full pipe
        for (int k = 0; k < 4; k++) run_cycle(1'b1, W'(8'hB0 + k), 1'b0, 1'b0, '0);
        drive(1'b1, 64'hB4, 1'b1, 1'b1, 3'd2);
        mid_check();
        chk("fl2_out_valid", W'(e_out_valid), W'(1'b1));
        chk("fl2_out_data", e_out_data, 64'hB0);
        chk("fl2_in_ready", W'(e_in_ready), W'(1'b0));
        chk("fl2_lck_in_ready", W'(l_in_ready), W'(1'b0));
        end_cycle();
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        mid_check();
        chk("fl2_after_sv", W'(e_sv), W'(4'b1000));
        chk("fl2_after_data", e_out_data, 64'hB1);
        chk("fl2_after_count", W'(e_cnt), W'(3'd1));
        chk("fl2_after_lck_sv", W'(l_sv), W'(4'b1000));
        end_cycle();

        // flush everything while the output transfers
        drive(1'b0, '0, 1'b1, 1'b1, 3'd4);
        mid_check();
        chk("flD_out_valid", W'(e_out_valid), W'(1'b1));
        end_cycle();
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        mid_check();
        chk("flD_after_count", W'(e_cnt), W'(3'd0));
        chk("flD_after_lck_count", W'(l_cnt), W'(3'd0));
        end_cycle();

        // flush_idx=0 blocks only the incoming entry
        run_cycle(1'b1, 64'hD0, 1'b0, 1'b0, '0);
        run_cycle(1'b1, 64'hD1, 1'b0, 1'b0, '0);
        drive(1'b1, 64'hD2, 1'b1, 1'b1, 3'd0);
        mid_check();
        chk("fl0_in_ready", W'(e_in_ready), W'(1'b0));
        end_cycle();
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        mid_check();
        chk("fl0_after_sv", W'(e_sv), W'(4'b0110));
        chk("fl0_after_lck_sv", W'(l_sv), W'(4'b0110));
        end_cycle();
        drain();

        // randomized traffic with occasional flushes, including indices past DEPTH
        for (int c = 0; c < 1500; c++) begin
            run_cycle($urandom_range(0, 99) < 70, {$urandom, $urandom},
                      $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 10,
                      IW'($urandom_range(0, 7)));
        end

        // asynchronous reset between edges
        run_cycle(1'b1, 64'hE0, 1'b1, 1'b0, '0);
        run_cycle(1'b1, 64'hE1, 1'b1, 1'b0, '0);
        run_cycle(1'b1, 64'hE2, 1'b1, 1'b0, '0);
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ela_sv", W'(e_sv), W'(4'b0000));
        chk("arst_ela_out_valid", W'(e_out_valid), W'(1'b0));
        chk("arst_lck_sv", W'(l_sv), W'(4'b0000));
        chk("arst_lck_out_valid", W'(l_out_valid), W'(1'b0));
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 64'hF0, 1'b1, 1'b0, '0);
        mid_check();
        chk("arst_rel_in_ready", W'(e_in_ready), W'(1'b1));
        end_cycle();
        lat = 0;
        found = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            drive(1'b0, '0, 1'b1, 1'b0, '0);
            mid_check();
            if (!found && e_out_valid) begin
                found = 1'b1;
                lat = k;
            end
            end_cycle();
        end
        chk("arst_rel_latency", W'(lat), W'(D));

        chk("ela_transfers", W'(dut_xfer[0]), W'(mdl_xfer[0]));
        chk("lck_transfers", W'(dut_xfer[1]), W'(mdl_xfer[1]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
